// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ producers.
// A winner keeps the port for up to MAXBURST words; wfull stalls it in place.
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input  logic                    wclk,
  input  logic                    wrst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  input  logic                    wfull,
  output logic                    winc,
  output logic [DSIZE-1:0]        wdata,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAXBURST - 1);
  localparam logic [OW-1:0] OWNER_RST = OW'(NREQ - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OW-1:0]    pick_s;
  logic             found_s;
  logic             winc_s;
  logic [DSIZE-1:0] slot_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign slot_s[g] = req_data[g*DSIZE +: DSIZE];
  end

  // Round-robin search: first requester strictly after the pointer, wrapping.
  always_comb begin
    pick_s  = owner_q;
    found_s = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found_s && req[OW'((int'(owner_q) + k) % NREQ)]) begin
        pick_s  = OW'((int'(owner_q) + k) % NREQ);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Write strobe and next-state logic.
  always_comb begin
    winc_s  = (state_q == BURST) && req[owner_q] && !wfull;
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          owner_d = pick_s;
          cnt_d   = {CW{1'b0}};
          state_d = BURST;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (!req[owner_q]) begin
          // Early release: owner stays as the round-robin pointer.
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else if (wfull) begin
          state_d = BURST;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      owner_q <= OWNER_RST;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign winc  = winc_s;
  assign gnt   = winc_s ? (NREQ'(1) << owner_q) : {NREQ{1'b0}};
  assign wdata = slot_s[owner_q];
  assign busy  = (state_q == BURST);
  assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: burst length, rotation, stall,
// early release, mid-burst reset and wrap-around search.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [7:0]  d [4];
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic        wfull = 1'b0;
  logic        winc;
  logic [7:0]  wdata;
  logic        busy;
  logic [1:0]  owner;
  int          checks = 0;
  int          errors = 0;

  assign req_data = {d[3], d[2], d[1], d[0]};

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAXBURST(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .wfull(wfull), .winc(winc), .wdata(wdata),
    .busy(busy), .owner(owner)
  );

  always #30 wclk = ~wclk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; producers step their data after an accepted word.
  task automatic tick();
    logic [3:0] g;
    #1;
    g = gnt;
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) if (g[i]) d[i] = d[i] + 8'd1;
    @(negedge wclk);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    #1;
    chk_val("rst_winc", {31'd0, winc}, 32'd0);
    chk_val("rst_gnt", {28'd0, gnt}, 32'd0);
    chk_val("rst_busy", {31'd0, busy}, 32'd0);
    chk_val("rst_owner", {30'd0, owner}, 32'd3);
    chk_val("rst_wdata", {24'd0, wdata}, {24'd0, d[3]});
    tick();
    tick();
    wrst_n = 1'b1;
  endtask

  initial begin
    d[0] = 8'hA0; d[1] = 8'h10; d[2] = 8'h20; d[3] = 8'h30;
    @(negedge wclk);
    do_reset();

    // Single requester: 4-word bursts separated by one gap cycle.
    req = 4'b0001;
    #1 chk_val("t1_c0_winc", {31'd0, winc}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_val("t1_gnt", {28'd0, gnt}, 32'h1);
      chk_val("t1_wdata", {24'd0, wdata}, 32'hA0 + k);
    end
    tick();
    chk_val("t1_gap_winc", {31'd0, winc}, 32'd0);
    chk_val("t1_gap_busy", {31'd0, busy}, 32'd0);
    tick();
    chk_val("t1_a4_gnt", {28'd0, gnt}, 32'h1);
    chk_val("t1_a4_wdata", {24'd0, wdata}, 32'hA4);
    req = 4'b0000;
    tick();
    chk_val("t1_release_busy", {31'd0, busy}, 32'd0);

    // All requesters active: order 0,1,2,3,0 with one gap between bursts.
    do_reset();
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      tick();
      for (int w = 0; w < 4; w++) begin
        chk_val("t2_gnt", {28'd0, gnt}, 32'd1 << (b % 4));
        chk_val("t2_owner", {30'd0, owner}, b % 4);
        chk_val("t2_wdata", {24'd0, wdata}, {24'd0, d[b % 4]});
        tick();
      end
      chk_val("t2_gap_winc", {31'd0, winc}, 32'd0);
    end

    // Requester 2 stalled by wfull for 5 cycles after its second word.
    do_reset();
    d[2] = 8'h20;
    req = 4'b0100;
    tick();
    chk_val("t3_w0", {24'd0, wdata}, 32'h20);
    tick();
    chk_val("t3_w1", {24'd0, wdata}, 32'h21);
    tick();
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk_val("t3_stall_winc", {31'd0, winc}, 32'd0);
      chk_val("t3_stall_gnt", {28'd0, gnt}, 32'd0);
      chk_val("t3_stall_owner", {30'd0, owner}, 32'd2);
      chk_val("t3_stall_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    wfull = 1'b0;
    #1 chk_val("t3_w2", {24'd0, wdata}, 32'h22);
    chk_val("t3_w2_gnt", {28'd0, gnt}, 32'h4);
    tick();
    chk_val("t3_w3", {24'd0, wdata}, 32'h23);
    chk_val("t3_w3_gnt", {28'd0, gnt}, 32'h4);
    tick();
    chk_val("t3_end_busy", {31'd0, busy}, 32'd0);

    // Requester 1 releases after one word; pointer then favours requester 2.
    req = 4'b0110;
    tick();
    chk_val("t4_gnt1", {28'd0, gnt}, 32'h2);
    tick();
    req = 4'b0100;
    #1 chk_val("t4_drop_winc", {31'd0, winc}, 32'd0);
    tick();
    chk_val("t4_gap_busy", {31'd0, busy}, 32'd0);
    req = 4'b0110;
    tick();
    chk_val("t4_next_owner", {30'd0, owner}, 32'd2);
    chk_val("t4_next_gnt", {28'd0, gnt}, 32'h4);

    // Only requester 3 after reset: search wraps and picks 3.
    do_reset();
    req = 4'b1000;
    tick();
    chk_val("t6_gnt3", {28'd0, gnt}, 32'h8);
    chk_val("t6_owner3", {30'd0, owner}, 32'd3);
    tick();
    chk_val("t5_busy", {31'd0, busy}, 32'd1);

    // Reset mid-burst: write strobe drops at once, requester 1 wins after.
    wrst_n = 1'b0;
    #1;
    chk_val("t5_rst_winc", {31'd0, winc}, 32'd0);
    chk_val("t5_rst_gnt", {28'd0, gnt}, 32'd0);
    tick();
    wrst_n = 1'b1;
    req = 4'b1010;
    #1 chk_val("t5_idle_winc", {31'd0, winc}, 32'd0);
    tick();
    chk_val("t5_gnt1", {28'd0, gnt}, 32'h2);
    chk_val("t5_owner1", {30'd0, owner}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
